// File: rtl/codec_cfg_pkg.sv
// Shared constants for the audio codec configuration sequencer: device address,
// register map, boot register table and FSM state encoding.
package codec_cfg_pkg;

  localparam logic [6:0] DEV_ADDR = 7'h1A;
  localparam int         NUM_REGS = 7;

  localparam logic [6:0] R_LHPOUT  = 7'h02;
  localparam logic [6:0] R_ANALOG  = 7'h04;
  localparam logic [6:0] R_DIGITAL = 7'h05;
  localparam logic [6:0] R_IFACE   = 7'h07;
  localparam logic [6:0] R_SRATE   = 7'h08;
  localparam logic [6:0] R_ACTIVE  = 7'h09;
  localparam logic [6:0] R_RESET   = 7'h0F;

  localparam logic [2:0] LAST_IDX      = 3'(NUM_REGS - 1);
  localparam logic [2:0] VOL_ERR_INDEX = 3'd7;

  // Each word is {reg_addr[6:0], reg_data[8:0]}, written in this order at boot
  localparam logic [15:0] CFG_TABLE [0:NUM_REGS-1] = '{
    {R_RESET,   9'h000},
    {R_DIGITAL, 9'h006},
    {R_ANALOG,  9'h010},
    {R_LHPOUT,  9'h179},
    {R_IFACE,   9'h00A},
    {R_SRATE,   9'h000},
    {R_ACTIVE,  9'h001}
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_XFER,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

endpackage

// File: rtl/cfg_timer.sv
// Loadable down-counter shared by the sequencer's power-up, gap and timeout phases.
module cfg_timer #(
  parameter int W = 8
) (
  input  logic         clk_50,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Boot and runtime configuration controller for the audio codec: writes the register
// table through the external I2C engine with retries, then serves volume updates.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int PWRUP_CYCLES   = 50000,
  parameter int GAP_CYCLES     = 500,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        start,
  input  logic        vol_req,
  input  logic [6:0]  vol_val,
  output logic        vol_ack,
  output logic        i2c_req,
  output logic [6:0]  i2c_dev,
  output logic [15:0] i2c_word,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        configured,
  output logic        busy,
  output logic        cfg_error,
  output logic [2:0]  err_index
);

  localparam int CNT_MAX = (PWRUP_CYCLES > GAP_CYCLES)
                         ? ((PWRUP_CYCLES > TIMEOUT_CYCLES) ? PWRUP_CYCLES : TIMEOUT_CYCLES)
                         : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  // The counter is loaded on entry and the state moves on the cycle it reads zero, so
  // power-up spans PWRUP_CYCLES+1 cycles while gaps and the timeout span exactly their count.
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWRUP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  cfg_state_t         state_q, state_d;
  logic [2:0]         idx_q;
  logic [RETRY_W-1:0] retry_q;
  logic               vol_mode_q;
  logic [6:0]         vol_code_q;
  logic               configured_q, cfg_error_q;
  logic [2:0]         err_index_q;

  logic               start_ok, xfer_ok, xfer_fail, retry_exhausted;
  logic               timer_load, timer_zero;
  logic [CNT_W-1:0]   load_val;
  logic [15:0]        vol_word;

  cfg_timer #(.W(CNT_W)) u_timer (
    .clk_50   (clk_50),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (load_val),
    .zero     (timer_zero)
  );

  assign retry_exhausted = (int'(retry_q) + 1 >= MAX_RETRY);
  assign vol_word        = {R_LHPOUT, 1'b1, 1'b0, vol_code_q};

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    vol_ack   = 1'b0;
    xfer_ok   = 1'b0;
    xfer_fail = 1'b0;
    load_val  = '0;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_PWR_WAIT;
        end
      end
      ST_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_PWR_WAIT;
        end else if (vol_req) begin
          vol_ack = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_PWR_WAIT, ST_GAP: begin
        if (timer_zero) state_d = ST_XFER;
      end
      ST_XFER: begin
        // A done arriving on the last timeout cycle still counts as the engine's answer
        if (i2c_done) begin
          xfer_ok   = !i2c_nack;
          xfer_fail = i2c_nack;
        end else if (timer_zero) begin
          xfer_fail = 1'b1;
        end
        if (xfer_ok)
          state_d = (vol_mode_q || idx_q == LAST_IDX) ? ST_DONE : ST_GAP;
        else if (xfer_fail)
          state_d = retry_exhausted ? ST_ERROR : ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_PWR_WAIT: load_val = PWR_LOAD;
      ST_GAP:      load_val = GAP_LOAD;
      ST_XFER:     load_val = TMO_LOAD;
      default:     load_val = '0;
    endcase
  end

  assign timer_load = (state_d != state_q);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      retry_q      <= '0;
      vol_mode_q   <= 1'b0;
      vol_code_q   <= '0;
      configured_q <= 1'b0;
      cfg_error_q  <= 1'b0;
      err_index_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        idx_q        <= '0;
        retry_q      <= '0;
        vol_mode_q   <= 1'b0;
        configured_q <= 1'b0;
        cfg_error_q  <= 1'b0;
        err_index_q  <= '0;
      end else if (vol_ack) begin
        vol_mode_q <= 1'b1;
        vol_code_q <= vol_val;
        retry_q    <= '0;
      end else if (xfer_ok) begin
        retry_q <= '0;
        if (!vol_mode_q) begin
          if (idx_q == LAST_IDX) configured_q <= 1'b1;
          else                   idx_q        <= idx_q + 3'd1;
        end
      end else if (xfer_fail) begin
        if (retry_exhausted) begin
          cfg_error_q  <= 1'b1;
          configured_q <= 1'b0;
          err_index_q  <= vol_mode_q ? VOL_ERR_INDEX : idx_q;
        end else begin
          retry_q <= retry_q + 1'b1;
        end
      end
    end
  end

  // Bus fields are driven only while a write is requested, so an idle block shows all zeros
  assign i2c_req    = (state_q == ST_XFER);
  assign i2c_dev    = i2c_req ? DEV_ADDR : '0;
  assign i2c_word   = i2c_req ? (vol_mode_q ? vol_word : CFG_TABLE[idx_q]) : '0;
  assign busy       = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign configured = configured_q;
  assign cfg_error  = cfg_error_q;
  assign err_index  = err_index_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Self-checking bench for codec_cfg_sequencer: an I2C engine model answering after 20 cycles,
// table-driven failure scenarios, randomized response patterns and volume/reset sequences.
module tb_codec_cfg_sequencer;

  localparam int PWRUP   = 10;
  localparam int GAP     = 4;
  localparam int TMO     = 50;
  localparam int RETRY   = 3;
  localparam int ENG_LAT = 20;

  localparam int R_ACK    = 0;
  localparam int R_NACK   = 1;
  localparam int R_SILENT = 2;

  logic        clk_50 = 1'b0;
  logic        reset_n, start, vol_req;
  logic [6:0]  vol_val;
  logic        vol_ack, i2c_req, i2c_done, i2c_nack;
  logic [6:0]  i2c_dev;
  logic [15:0] i2c_word;
  logic        configured, busy, cfg_error;
  logic [2:0]  err_index;

  codec_cfg_sequencer #(
    .PWRUP_CYCLES   (PWRUP),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (RETRY)
  ) dut (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .start      (start),
    .vol_req    (vol_req),
    .vol_val    (vol_val),
    .vol_ack    (vol_ack),
    .i2c_req    (i2c_req),
    .i2c_dev    (i2c_dev),
    .i2c_word   (i2c_word),
    .i2c_done   (i2c_done),
    .i2c_nack   (i2c_nack),
    .configured (configured),
    .busy       (busy),
    .cfg_error  (cfg_error),
    .err_index  (err_index)
  );

  always #5 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  logic [15:0] ref_table [7] = '{16'h1E00, 16'h0A06, 16'h0810, 16'h0579,
                                 16'h0E0A, 16'h1000, 16'h1201};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      passed++;
  endtask

  // Monitor: cycle numbers of every rising and falling edge of i2c_req
  int   rise_log[$];
  int   fall_log[$];
  logic prev_req = 1'b0;

  initial begin
    forever begin
      @(negedge clk_50);
      if (i2c_req && !prev_req) rise_log.push_back(cyc);
      if (!i2c_req && prev_req) fall_log.push_back(cyc);
      prev_req = i2c_req;
    end
  end

  // Engine model: answers each request ENG_LAT cycles after it appears, per the response plan
  int          eng_plan[$];
  logic [15:0] word_log[$];
  bit          eng_active = 1'b0;
  int          eng_cnt;
  int          eng_resp;
  logic [15:0] eng_word;

  initial begin
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    forever begin
      @(negedge clk_50);
      if (i2c_done) begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        checkOutput("req_low_after_done", i2c_req, 0);
      end else if (eng_active) begin
        if (!i2c_req) begin
          eng_active = 1'b0;
        end else begin
          eng_cnt++;
          if (eng_cnt == ENG_LAT && eng_resp != R_SILENT) begin
            checkOutput("word_stable", i2c_word, eng_word);
            i2c_done   = 1'b1;
            i2c_nack   = (eng_resp == R_NACK);
            eng_active = 1'b0;
          end
        end
      end else if (i2c_req) begin
        eng_active = 1'b1;
        eng_cnt    = 0;
        eng_word   = i2c_word;
        eng_resp   = (eng_plan.size() > 0) ? eng_plan.pop_front() : R_ACK;
        word_log.push_back(i2c_word);
        checkOutput("dev_addr", i2c_dev, 7'h1A);
      end
    end
  end

  // Reference model: walks the table attempt by attempt using the response plan
  int          plan[$];
  logic [15:0] exp_words[$];
  int          exp_durs[$];
  logic        m_cfg, m_err;
  logic [2:0]  m_idx;

  task automatic model_boot();
    int p;
    int r;
    p = 0;
    exp_words.delete();
    exp_durs.delete();
    m_err = 1'b0;
    m_idx = 3'd0;
    for (int i = 0; i < 7 && !m_err; i++) begin
      for (int a = 0; a < RETRY; a++) begin
        r = (p < plan.size()) ? plan[p] : R_ACK;
        p++;
        exp_words.push_back(ref_table[i]);
        exp_durs.push_back((r == R_SILENT) ? TMO : ENG_LAT + 1);
        if (r == R_ACK) break;
        if (a == RETRY - 1) begin
          m_err = 1'b1;
          m_idx = 3'(i);
        end
      end
    end
    m_cfg = !m_err;
  endtask

  task automatic applyStimulus(input string tag, input logic exp_cfg, input logic exp_err,
                               input logic [2:0] exp_idx);
    int n;
    int start_edge;
    int lim;
    eng_plan = plan;
    rise_log.delete();
    fall_log.delete();
    word_log.delete();
    @(negedge clk_50);
    start      = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk_50);
    start = 1'b0;
    checkOutput({tag, "_busy_after_start"}, busy, 1);
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk_50);
      n++;
    end
    checkOutput({tag, "_finished_in_budget"}, (n < 4000), 1);
    repeat (2) @(negedge clk_50);
    checkOutput({tag, "_configured"}, configured, exp_cfg);
    checkOutput({tag, "_cfg_error"}, cfg_error, exp_err);
    checkOutput({tag, "_err_index"}, err_index, exp_idx);
    checkOutput({tag, "_req_idle"}, i2c_req, 0);
    checkOutput({tag, "_word_count"}, word_log.size(), exp_words.size());
    lim = (word_log.size() < exp_words.size()) ? word_log.size() : exp_words.size();
    for (int i = 0; i < lim; i++)
      checkOutput($sformatf("%s_word%0d", tag, i), word_log[i], exp_words[i]);
    if (rise_log.size() > 0)
      checkOutput({tag, "_first_req_delay"}, rise_log[0] - start_edge, PWRUP + 1);
    lim = (rise_log.size() < fall_log.size()) ? rise_log.size() : fall_log.size();
    if (exp_durs.size() < lim) lim = exp_durs.size();
    for (int i = 0; i < lim; i++) begin
      checkOutput($sformatf("%s_req_len%0d", tag, i), fall_log[i] - rise_log[i], exp_durs[i]);
      if (i > 0)
        checkOutput($sformatf("%s_gap%0d", tag, i), rise_log[i] - fall_log[i-1], GAP);
    end
  endtask

  typedef struct {
    int         fail_idx;
    int         fail_n;
    int         kind;
    logic       exp_cfg;
    logic       exp_err;
    logic [2:0] exp_idx;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int early;
    int n_rise;

    vecs[0] = '{0, 0, R_ACK,    1'b1, 1'b0, 3'd0};
    vecs[1] = '{2, 1, R_NACK,   1'b1, 1'b0, 3'd0};
    vecs[2] = '{4, 3, R_NACK,   1'b0, 1'b1, 3'd4};
    vecs[3] = '{0, 0, R_ACK,    1'b1, 1'b0, 3'd0};
    vecs[4] = '{0, 3, R_SILENT, 1'b0, 1'b1, 3'd0};
    vecs[5] = '{6, 2, R_SILENT, 1'b1, 1'b0, 3'd0};
    vecs[6] = '{6, 3, R_NACK,   1'b0, 1'b1, 3'd6};

    reset_n = 1'b0;
    start   = 1'b0;
    vol_req = 1'b0;
    vol_val = 7'h00;
    repeat (3) @(negedge clk_50);
    checkOutput("reset_req", i2c_req, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_configured", configured, 0);
    checkOutput("reset_cfg_error", cfg_error, 0);
    checkOutput("reset_err_index", err_index, 0);
    checkOutput("reset_word", i2c_word, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_50);
    checkOutput("idle_after_release", busy, 0);
    vol_req = 1'b1;
    #1;
    checkOutput("no_vol_ack_in_idle", vol_ack, 0);
    @(negedge clk_50);
    vol_req = 1'b0;

    for (int v = 0; v < 7; v++) begin
      plan.delete();
      for (int i = 0; i < vecs[v].fail_idx; i++) plan.push_back(R_ACK);
      for (int k = 0; k < vecs[v].fail_n; k++) plan.push_back(vecs[v].kind);
      model_boot();
      applyStimulus($sformatf("vec%0d", v), vecs[v].exp_cfg, vecs[v].exp_err, vecs[v].exp_idx);
    end

    for (int r = 0; r < 8; r++) begin
      int x;
      plan.delete();
      for (int k = 0; k < 21; k++) begin
        x = $urandom_range(0, 9);
        plan.push_back((x < 7) ? R_ACK : ((x < 9) ? R_NACK : R_SILENT));
      end
      model_boot();
      applyStimulus($sformatf("rand%0d", r), m_cfg, m_err, m_idx);
    end

    // Volume write from DONE; vol_val changes after the ack to prove it was latched
    plan.delete();
    model_boot();
    applyStimulus("vol_boot", 1'b1, 1'b0, 3'd0);
    @(negedge clk_50);
    vol_val = 7'h50;
    vol_req = 1'b1;
    #1;
    checkOutput("vol_ack_in_done", vol_ack, 1);
    @(negedge clk_50);
    checkOutput("vol_ack_single_cycle", vol_ack, 0);
    checkOutput("vol_busy", busy, 1);
    vol_req = 1'b0;
    vol_val = 7'h11;
    word_log.delete();
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk_50);
      n++;
    end
    checkOutput("vol_finished_in_budget", (n < 500), 1);
    checkOutput("vol_word_count", word_log.size(), 1);
    if (word_log.size() > 0) checkOutput("vol_word", word_log[0], 16'h0550);
    checkOutput("vol_configured", configured, 1);
    checkOutput("vol_cfg_error", cfg_error, 0);

    // Held vol_req across a reboot; a start mid-boot must be ignored
    word_log.delete();
    eng_plan.delete();
    @(negedge clk_50);
    vol_val = 7'h23;
    vol_req = 1'b1;
    start   = 1'b1;
    #1;
    checkOutput("start_beats_vol_req", vol_ack, 0);
    @(negedge clk_50);
    start = 1'b0;
    n     = 0;
    early = 0;
    while (!configured && n < 2000) begin
      @(negedge clk_50);
      n++;
      start = (n == 40);
      if (vol_ack && !configured) early++;
    end
    start = 1'b0;
    checkOutput("held_vol_boot_in_budget", (n < 2000), 1);
    checkOutput("no_vol_ack_during_boot", early, 0);
    checkOutput("vol_ack_once_done", vol_ack, 1);
    @(posedge clk_50);
    #1;
    vol_req = 1'b0;
    n = 0;
    while ((busy || word_log.size() < 8) && n < 500) begin
      @(negedge clk_50);
      n++;
    end
    checkOutput("held_vol_word_count", word_log.size(), 8);
    for (int i = 0; i < 7 && i < word_log.size(); i++)
      checkOutput($sformatf("held_vol_table%0d", i), word_log[i], ref_table[i]);
    if (word_log.size() >= 8) checkOutput("held_vol_word", word_log[7], 16'h0523);
    checkOutput("held_vol_configured", configured, 1);

    // Asynchronous reset in the middle of a volume write
    @(negedge clk_50);
    vol_val = 7'h05;
    vol_req = 1'b1;
    @(negedge clk_50);
    vol_req = 1'b0;
    n = 0;
    while (!i2c_req && n < 100) begin
      @(negedge clk_50);
      n++;
    end
    checkOutput("reset_test_req_seen", i2c_req, 1);
    checkOutput("reset_test_configured_before", configured, 1);
    @(negedge clk_50);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_req", i2c_req, 0);
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_configured", configured, 0);
    checkOutput("async_reset_word", i2c_word, 0);
    repeat (3) @(negedge clk_50);
    reset_n = 1'b1;
    n_rise  = rise_log.size();
    repeat (30) @(negedge clk_50);
    checkOutput("post_reset_idle", busy, 0);
    checkOutput("post_reset_no_req", rise_log.size(), n_rise);

    plan.delete();
    model_boot();
    applyStimulus("post_reset_boot", 1'b1, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
